// File: rtl/json_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : json_pkg                                                  |
// | Purpose  : FSM state encoding and JSON punctuation for json_gen      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package json_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_OPEN  = 4'd1,
    ST_KQ1   = 4'd2,
    ST_KEY   = 4'd3,
    ST_KQ2   = 4'd4,
    ST_COLON = 4'd5,
    ST_VQ1   = 4'd6,
    ST_VAL   = 4'd7,
    ST_VQ2   = 4'd8,
    ST_COMMA = 4'd9,
    ST_CLOSE = 4'd10,
    ST_SPACE = 4'd11,
    ST_DONE  = 4'd12
  } json_state_e;

  localparam logic [7:0] c_lbrace     = 8'h7B;  // '{'
  localparam logic [7:0] c_rbrace     = 8'h7D;  // '}'
  localparam logic [7:0] c_quote      = 8'h22;  // '"'
  localparam logic [7:0] c_colon      = 8'h3A;  // ':'
  localparam logic [7:0] c_comma      = 8'h2C;  // ','
  localparam logic [7:0] c_space      = 8'h20;  // ' '
  localparam logic [7:0] c_key_base   = 8'h61;  // 'a'
  localparam logic [7:0] c_digit_base = 8'h30;  // '0'

endpackage
`default_nettype wire

// File: rtl/json_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : json_gen                                                  |
// | Purpose  : Streams one synthetic JSON object per start request       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module json_gen
  import json_pkg::*;
#(
  parameter int MAX_PAIRS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pair_cnt,
  input  logic [2:0] key_len,
  input  logic [2:0] val_len,
  input  logic       ready,
  output logic [7:0] char,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] c_max_pairs = MAX_PAIRS[3:0];

  json_state_e r_state;
  json_state_e w_next_state;

  logic [3:0] r_pair_n;
  logic [2:0] r_key_len;
  logic [2:0] r_val_len;
  logic [3:0] r_pair_idx;
  logic [2:0] r_char_idx;
  logic [3:0] w_next_pair_idx;
  logic [2:0] w_next_char_idx;

  logic [7:0] r_char;
  logic       r_valid;
  logic       r_busy;
  logic       r_done;

  logic       w_hs;
  logic       w_accept;
  logic [3:0] w_pair_sat;
  logic [3:0] w_pair_last;
  logic [2:0] w_key_last;
  logic [2:0] w_val_last;
  logic [3:0] w_digit;
  logic [7:0] w_next_char;
  logic       w_next_valid;

  assign w_hs        = r_valid & ready;
  assign w_accept    = (r_state == ST_IDLE) & start;
  assign w_pair_sat  = (pair_cnt > c_max_pairs) ? c_max_pairs : pair_cnt;
  assign w_pair_last = r_pair_n - 4'd1;
  assign w_key_last  = r_key_len - 3'd1;
  assign w_val_last  = r_val_len - 3'd1;

  // Next state and counters; every non-idle move is gated by the handshake.
  always_comb begin
    w_next_state    = r_state;
    w_next_pair_idx = r_pair_idx;
    w_next_char_idx = r_char_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state    = ST_OPEN;
          w_next_pair_idx = 4'd0;
          w_next_char_idx = 3'd0;
        end
      end
      ST_OPEN: begin
        if (w_hs) w_next_state = (r_pair_n == 4'd0) ? ST_CLOSE : ST_KQ1;
      end
      ST_KQ1: begin
        if (w_hs) begin
          w_next_char_idx = 3'd0;
          w_next_state    = (r_key_len == 3'd0) ? ST_KQ2 : ST_KEY;
        end
      end
      ST_KEY: begin
        if (w_hs) begin
          if (r_char_idx == w_key_last) w_next_state = ST_KQ2;
          else                          w_next_char_idx = r_char_idx + 3'd1;
        end
      end
      ST_KQ2: begin
        if (w_hs) w_next_state = ST_COLON;
      end
      ST_COLON: begin
        if (w_hs) w_next_state = ST_VQ1;
      end
      ST_VQ1: begin
        if (w_hs) begin
          w_next_char_idx = 3'd0;
          w_next_state    = (r_val_len == 3'd0) ? ST_VQ2 : ST_VAL;
        end
      end
      ST_VAL: begin
        if (w_hs) begin
          if (r_char_idx == w_val_last) w_next_state = ST_VQ2;
          else                          w_next_char_idx = r_char_idx + 3'd1;
        end
      end
      ST_VQ2: begin
        if (w_hs) begin
          if (r_pair_idx == w_pair_last) begin
            w_next_state = ST_CLOSE;
          end else begin
            w_next_state    = ST_COMMA;
            w_next_pair_idx = r_pair_idx + 4'd1;
          end
        end
      end
      ST_COMMA: begin
        if (w_hs) w_next_state = ST_KQ1;
      end
      ST_CLOSE: begin
        if (w_hs) w_next_state = ST_SPACE;
      end
      ST_SPACE: begin
        if (w_hs) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Character for the state being entered, so char is registered with state.
  assign w_digit = (w_next_pair_idx >= 4'd10) ? (w_next_pair_idx - 4'd10) : w_next_pair_idx;

  always_comb begin
    w_next_char = 8'h00;
    case (w_next_state)
      ST_OPEN:                        w_next_char = c_lbrace;
      ST_KQ1, ST_KQ2, ST_VQ1, ST_VQ2: w_next_char = c_quote;
      ST_KEY:                         w_next_char = c_key_base + {4'd0, w_next_pair_idx};
      ST_VAL:                         w_next_char = c_digit_base + {4'd0, w_digit};
      ST_COLON:                       w_next_char = c_colon;
      ST_COMMA:                       w_next_char = c_comma;
      ST_CLOSE:                       w_next_char = c_rbrace;
      ST_SPACE:                       w_next_char = c_space;
      default:                        w_next_char = 8'h00;
    endcase
  end

  assign w_next_valid = (w_next_state != ST_IDLE) && (w_next_state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pair_n   <= 4'd0;
      r_key_len  <= 3'd0;
      r_val_len  <= 3'd0;
      r_pair_idx <= 4'd0;
      r_char_idx <= 3'd0;
      r_char     <= 8'h00;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pair_idx <= w_next_pair_idx;
      r_char_idx <= w_next_char_idx;
      r_char     <= w_next_char;
      r_valid    <= w_next_valid;
      r_busy     <= w_next_valid;
      r_done     <= (w_next_state == ST_DONE);
      if (w_accept) begin
        r_pair_n  <= w_pair_sat;
        r_key_len <= key_len;
        r_val_len <= val_len;
      end
    end
  end

  assign char  = r_char;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_json_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_json_gen                                               |
// | Purpose  : Directed self-checking bench for json_gen                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_json_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] pair_cnt;
  logic [2:0] key_len;
  logic [2:0] val_len;
  logic       ready;
  logic [7:0] char;
  logic       valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  json_gen #(.MAX_PAIRS(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pair_cnt (pair_cnt),
    .key_len  (key_len),
    .val_len  (val_len),
    .ready    (ready),
    .char     (char),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
  endtask

  // Issue one start, then consume the object and compare it with exp.
  task automatic run_obj(input string tag, input logic [3:0] n, input logic [2:0] kl,
                         input logic [2:0] vl, input bit toggle, input bit dup_start,
                         input string exp);
    int idx = 0;
    int cyc = 0;
    bit holding = 1'b0;
    logic [7:0] held = 8'h00;
    pair_cnt = n; key_len = kl; val_len = vl; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; pair_cnt = 4'd9; key_len = 3'd5; val_len = 3'd6;
    check({tag, "_lat_valid"}, {31'd0, valid}, 32'd1);
    check({tag, "_lat_char"},  {24'd0, char},  32'h7B);
    while (idx < exp.len() && cyc < 500) begin
      ready = toggle ? cyc[0] : 1'b1;
      if (dup_start) start = (cyc == 3);
      if (holding) check({tag, "_hold"}, {24'd0, char}, {24'd0, held});
      if (!valid) begin
        check({tag, "_valid_gap"}, {31'd0, valid}, 32'd1);
        break;
      end
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      holding = !ready;
      held    = char;
      if (ready) begin
        check({tag, "_char"}, {24'd0, char}, {24'd0, exp[idx]});
        idx++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    check({tag, "_count"}, idx, exp.len());
    check({tag, "_done"},  {31'd0, done},  32'd1);
    check({tag, "_dvalid"}, {31'd0, valid}, 32'd0);
    check({tag, "_dbusy"},  {31'd0, busy},  32'd0);
    if (dup_start) start = 1'b1;
    tick();
    start = 1'b0;
    check_quiet({tag, "_idle"});
    tick();
    check_quiet({tag, "_idle2"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pair_cnt = 4'd0; key_len = 3'd0; val_len = 3'd0; ready = 1'b0;
    tick();
    tick();
    check("rst_char", {24'd0, char}, 32'h00);
    check_quiet("rst");
    reset = 1'b0;
    tick();
    check_quiet("idle0");

    run_obj("empty",   4'd0, 3'd0, 3'd0, 1'b0, 1'b0, "{} ");
    run_obj("two",     4'd2, 3'd1, 3'd2, 1'b0, 1'b0, "{\"a\":\"00\",\"b\":\"11\"} ");
    run_obj("zerolen", 4'd1, 3'd0, 3'd0, 1'b0, 1'b0, "{\"\":\"\"} ");
    run_obj("toggle",  4'd2, 3'd1, 3'd2, 1'b1, 1'b0, "{\"a\":\"00\",\"b\":\"11\"} ");
    run_obj("three",   4'd3, 3'd2, 3'd1, 1'b0, 1'b0, "{\"aa\":\"0\",\"bb\":\"1\",\"cc\":\"2\"} ");
    run_obj("dup",     4'd1, 3'd1, 3'd1, 1'b0, 1'b1, "{\"a\":\"0\"} ");

    // Abort mid-object after the fifth accepted character.
    pair_cnt = 4'd2; key_len = 3'd1; val_len = 3'd2; start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_pre_char", {24'd0, char}, 32'h22);
    reset = 1'b1;
    tick();
    check("abort_char", {24'd0, char}, 32'h00);
    check_quiet("abort");
    reset = 1'b0;
    tick();
    check_quiet("abort_after");
    run_obj("restart", 4'd2, 3'd1, 3'd2, 1'b0, 1'b0, "{\"a\":\"00\",\"b\":\"11\"} ");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
